ddram_read_arbiter: RTL and testbench
=====================================

// Module: ddram_read_arbiter
// PURPOSE
//  Shares the DDRAM Avalon burst-read port between two read requesters (ch0, ch1) with
//  round-robin arbitration. Keeps exactly one burst outstanding and routes returned beats
//  to the owning channel. Supports a safe stop: the current burst drains, then the port idles.
//  Sits between core read clients and DDRAM_* in emu, on the DDRAM clock domain.
// PARAMETERS
//  AW        29   DDRAM word address width
//  DW        64   data width
//  BW        8    burst count width
//  MAXBURST  128  largest burst issued; longer requests are clamped
// PORTS
//  clk             in   1    DDRAM clock (DDRAM_CLK domain); sole clock
//  reset_n         in   1    asynchronous, active-low reset
//  req0/req1       in   1    read request; hold with addr/len stable until gnt
//  addr0/addr1     in   AW   burst start address
//  len0/len1       in   BW   beats requested
//  gnt0/gnt1       out  1    1-cycle pulse: request accepted and latched
//  dv0/dv1         out  1    rdata valid for that channel
//  rdata           out  DW   returned beat, shared by both channels
//  stop_req        in   1    level; request safe stop
//  stopped         out  1    high while idle because of stop_req
//  err             out  1    sticky; DDRAM data returned with no burst outstanding
//  ddr_busy        in   1    DDRAM_BUSY (waitrequest)
//  ddr_rd          out  1    DDRAM_RD
//  ddr_addr        out  AW   DDRAM_ADDR
//  ddr_burstcnt    out  BW   DDRAM_BURSTCNT
//  ddr_dout        in   DW   DDRAM_DOUT
//  ddr_dout_ready  in   1    DDRAM_DOUT_READY
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_gnt=1, so ch0 wins the first tie.
//  Reset is asynchronous and may land mid-burst. Beats still in flight then arrive in IDLE and set err.
//  States: IDLE, CMD, DATA, STOP. All outputs are registered.
//  IDLE:
//   - stop_req=1 has priority over requests -> STOP.
//   - Otherwise, with one requester asserted, grant it.
//   - With both asserted, grant the channel opposite last_gnt.
//   - On grant: pulse gntN; latch owner, ddr_addr=addrN, ddr_burstcnt=eff_len.
//     eff_len = (lenN==0) ? 1 : min(lenN, MAXBURST).
//   - On grant: set ddr_rd=1, beat_cnt=0, last_gnt=N; -> CMD.
//  CMD: ddr_rd, ddr_addr and ddr_burstcnt are held stable while ddr_busy=1.
//   - The command is accepted on the edge where ddr_rd=1 and ddr_busy=0.
//   - That edge clears ddr_rd and enters DATA.
//  DATA: on each edge with ddr_dout_ready=1:
//   - next cycle: rdata=ddr_dout and dvOWNER=1. Latency is 1 clock; the other dv stays 0.
//   - beat_cnt increments on each such edge.
//   - On beat eff_len: go to STOP if stop_req=1, else IDLE.
//   - A new grant is possible no earlier than the cycle after the last dv.
//   - ddr_busy is ignored in DATA.
//  STOP: stopped=1, no commands issued; stop_req=0 -> IDLE (stopped=0 next cycle).
//  stop_req raised in CMD or DATA never aborts the burst. It takes effect at burst end.
//  ddr_dout_ready outside DATA: data dropped, no dv, err<=1. Only reset clears err.
//  gnt and the first dv never coincide. dv0 and dv1 are never both high.
// TESTING
//  ch0 req addr=0x2400000 len=128, busy=0 -> gnt0 next cycle; ddr_rd high for exactly 1 cycle, burstcnt=0x80;
//   128 beats -> 128 dv0 pulses, 0 dv1, state back to IDLE.
//  req0 and req1 asserted together, len=4 each, both re-requesting -> grant order 0,1,0,1;
//   each grant only after the prior burst's 4th dv.
//  busy=1 for 10 cycles after grant -> ddr_rd/addr/burstcnt constant for 10 cycles; accepted on cycle 11.
//  len1=0 -> burstcnt=1, one dv1. len1=200 -> burstcnt=128, 128 dv1.
//  stop_req pulsed high at beat 3 of an 8-beat burst and held -> all 8 dv delivered, then stopped=1;
//   pending req0 not granted until stop_req falls.
//  reset_n low at beat 5 of 16 -> outputs 0 immediately; 11 stray beats -> err=1, no dv.

Source files
------------

// File: rtl/ddram_read_arbiter_if.sv
// DDRAM Avalon burst-read bus as seen by the read arbiter.
// The arbiter (master) issues read bursts; the memory side (slave) returns beats.
interface ddram_read_arbiter_if #(
  parameter int AW = 29,
  parameter int DW = 64,
  parameter int BW = 8
);
  logic          ddr_busy;
  logic          ddr_rd;
  logic [AW-1:0] ddr_addr;
  logic [BW-1:0] ddr_burstcnt;
  logic [DW-1:0] ddr_dout;
  logic          ddr_dout_ready;

  modport master (
    input  ddr_busy,
    input  ddr_dout,
    input  ddr_dout_ready,
    output ddr_rd,
    output ddr_addr,
    output ddr_burstcnt
  );

  modport slave (
    output ddr_busy,
    output ddr_dout,
    output ddr_dout_ready,
    input  ddr_rd,
    input  ddr_addr,
    input  ddr_burstcnt
  );
endinterface

// File: rtl/ddram_read_arbiter.sv
// Two-channel round-robin arbiter for the DDRAM burst-read port.
// Exactly one burst is outstanding at a time; returned beats are routed to the
// channel that owns the burst. A level stop request lets the current burst
// drain and then parks the port until the request is withdrawn.
module ddram_read_arbiter #(
  parameter int AW       = 29,
  parameter int DW       = 64,
  parameter int BW       = 8,
  parameter int MAXBURST = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [AW-1:0]         addr0,
  input  logic [AW-1:0]         addr1,
  input  logic [BW-1:0]         len0,
  input  logic [BW-1:0]         len1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  dv0,
  output logic                  dv1,
  output logic [DW-1:0]         rdata,
  input  logic                  stop_req,
  output logic                  stopped,
  output logic                  err,
  ddram_read_arbiter_if.master  ddr
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, STOP} state_t;

  state_t        state;
  logic          owner;
  logic          last_gnt;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] beat_nxt;
  logic          rd_q;
  logic [AW-1:0] addr_q;
  logic [BW-1:0] burst_q;
  logic          pick_valid;
  logic          pick;

  // Zero-length requests still fetch one beat; oversize requests are clamped.
  function automatic logic [BW-1:0] eff_len(input logic [BW-1:0] len);
    if (len == '0)
      return BW'(1);
    else if (int'(len) > MAXBURST)
      return BW'(MAXBURST);
    else
      return len;
  endfunction

  assign ddr.ddr_rd       = rd_q;
  assign ddr.ddr_addr     = addr_q;
  assign ddr.ddr_burstcnt = burst_q;
  assign beat_nxt         = beat_cnt + BW'(1);

  // Round-robin pick: a lone requester wins; on a tie the channel not granted last wins.
  always_comb begin
    pick_valid = req0 | req1;
    pick       = 1'b0;
    if (req0 && req1)
      pick = ~last_gnt;
    else
      pick = req1;
  end

  // Arbitration FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      burst_q  <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      dv0      <= 1'b0;
      dv1      <= 1'b0;
      rdata    <= '0;
      stopped  <= 1'b0;
      err      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      dv0  <= 1'b0;
      dv1  <= 1'b0;

      // Beats arriving with no accepted burst are dropped and flagged until reset.
      if (ddr.ddr_dout_ready && (state != DATA))
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (stop_req) begin
            state   <= STOP;
            stopped <= 1'b1;
          end else if (pick_valid) begin
            owner    <= pick;
            last_gnt <= pick;
            gnt0     <= ~pick;
            gnt1     <= pick;
            addr_q   <= pick ? addr1 : addr0;
            burst_q  <= eff_len(pick ? len1 : len0);
            rd_q     <= 1'b1;
            beat_cnt <= '0;
            state    <= CMD;
          end
        end

        CMD: begin
          // Command fields stay frozen until the memory drops waitrequest.
          if (!ddr.ddr_busy) begin
            rd_q  <= 1'b0;
            state <= DATA;
          end
        end

        DATA: begin
          if (ddr.ddr_dout_ready) begin
            rdata    <= ddr.ddr_dout;
            dv0      <= ~owner;
            dv1      <= owner;
            beat_cnt <= beat_nxt;
            if (beat_nxt == burst_q) begin
              if (stop_req) begin
                state   <= STOP;
                stopped <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        STOP: begin
          if (!stop_req) begin
            state   <= IDLE;
            stopped <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_read_arbiter.sv
// Directed bench for ddram_read_arbiter with a simple burst-responding memory.
module tb_ddram_read_arbiter;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] len0, len1;
  logic          gnt0, gnt1, dv0, dv1;
  logic [DW-1:0] rdata;
  logic          stop_req, stopped, err;

  ddram_read_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();

  ddram_read_arbiter #(.AW(AW), .DW(DW), .BW(BW), .MAXBURST(128)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .len0     (len0),
    .len1     (len1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .dv0      (dv0),
    .dv1      (dv1),
    .rdata    (rdata),
    .stop_req (stop_req),
    .stopped  (stopped),
    .err      (err),
    .ddr      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model state
  logic          mem_en = 1'b1;
  int            busy_left = 0;
  int            beats_left = 0;
  logic [AW-1:0] base = '0;
  logic [31:0]   beat_i = '0;
  logic [DW-1:0] exp_q[$];

  // monitor state
  int   dv0_cnt = 0;
  int   dv1_cnt = 0;
  int   data_bad = 0;
  logic both_dv = 1'b0;
  logic overlap = 1'b0;
  int   gnt_q[$];
  int   gnt_dvcnt[$];
  logic [DW-1:0] e;

  // Memory: accepts a command when not busy, then returns one beat per cycle.
  initial begin
    bus.ddr_busy = 1'b0;
    bus.ddr_dout_ready = 1'b0;
    bus.ddr_dout = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        beats_left = 0;
      end else begin
        bus.ddr_dout_ready = 1'b0;
        if (beats_left > 0) begin
          bus.ddr_dout = {3'b000, base, beat_i};
          bus.ddr_dout_ready = 1'b1;
          exp_q.push_back(bus.ddr_dout);
          beat_i = beat_i + 1;
          beats_left--;
        end else if (bus.ddr_rd) begin
          if (busy_left > 0) begin
            bus.ddr_busy = 1'b1;
            busy_left--;
          end else begin
            bus.ddr_busy = 1'b0;
            beats_left = int'(bus.ddr_burstcnt);
            base = bus.ddr_addr;
            beat_i = '0;
          end
        end else begin
          bus.ddr_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: counts grants and data beats, checks returned data order.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dv0 && dv1) both_dv = 1'b1;
      if ((gnt0 || gnt1) && (dv0 || dv1)) overlap = 1'b1;
      if (gnt0 || gnt1) begin
        gnt_q.push_back(gnt1 ? 1 : 0);
        gnt_dvcnt.push_back(dv0_cnt + dv1_cnt);
      end
      if (dv0) dv0_cnt++;
      if (dv1) dv1_cnt++;
      if (dv0 || dv1) begin
        if (exp_q.size() == 0) data_bad++;
        else begin
          e = exp_q.pop_front();
          if (rdata !== e) data_bad++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_counts();
    dv0_cnt = 0;
    dv1_cnt = 0;
    gnt_q.delete();
    gnt_dvcnt.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_dv(input int ch, input int target, input int budget);
    int n;
    n = 0;
    while (((ch == 0) ? dv0_cnt : dv1_cnt) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    exp_q.delete();
    clr_counts();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL rst_gnt0 got=%0h want=0", gnt0); end
    total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt1 got=%0h want=0", gnt1); end
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL rst_dv0 got=%0h want=0", dv0); end
    total++; if (dv1 !== 1'b0) begin bad++; $display("FAIL rst_dv1 got=%0h want=0", dv1); end
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", rdata); end
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL rst_stopped got=%0h want=0", stopped); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", err); end
    total++; if (bus.ddr_rd !== 1'b0) begin bad++; $display("FAIL rst_rd got=%0h want=0", bus.ddr_rd); end
    total++; if (bus.ddr_addr !== 29'h0) begin bad++; $display("FAIL rst_addr got=%0h want=0", bus.ddr_addr); end
    total++; if (bus.ddr_burstcnt !== 8'h0) begin bad++; $display("FAIL rst_burstcnt got=%0h want=0", bus.ddr_burstcnt); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_burst();
    clr_counts();
    req0 = 1'b1; addr0 = 29'h2400000; len0 = 8'd128;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL sb_gnt0 got=%0h want=1", gnt0); end
    total++; if (bus.ddr_rd !== 1'b1) begin bad++; $display("FAIL sb_rd_on got=%0h want=1", bus.ddr_rd); end
    total++; if (bus.ddr_burstcnt !== 8'h80) begin bad++; $display("FAIL sb_burstcnt got=%0h want=80", bus.ddr_burstcnt); end
    total++; if (bus.ddr_addr !== 29'h2400000) begin bad++; $display("FAIL sb_addr got=%0h want=2400000", bus.ddr_addr); end
    req0 = 1'b0;
    @(negedge clk);
    total++; if (bus.ddr_rd !== 1'b0) begin bad++; $display("FAIL sb_rd_off got=%0h want=0", bus.ddr_rd); end
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL sb_gnt0_pulse got=%0h want=0", gnt0); end
    wait_dv(0, 128, 400);
    idle(5);
    total++; if (dv0_cnt !== 128) begin bad++; $display("FAIL sb_dv0_count got=%0d want=128", dv0_cnt); end
    total++; if (dv1_cnt !== 0) begin bad++; $display("FAIL sb_dv1_count got=%0d want=0", dv1_cnt); end
    total++; if (data_bad !== 0) begin bad++; $display("FAIL sb_data got=%0d want=0", data_bad); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] order;
    do_reset();
    req0 = 1'b1; addr0 = 29'h100; len0 = 8'd4;
    req1 = 1'b1; addr1 = 29'h200; len1 = 8'd4;
    n = 0;
    while (gnt_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
    req0 = 1'b0; req1 = 1'b0;
    n = 0;
    while ((dv0_cnt + dv1_cnt) < 16 && n < 200) begin @(negedge clk); n++; end
    idle(5);
    total++; if (gnt_q.size() !== 4) begin bad++; $display("FAIL rr_gnt_count got=%0d want=4", gnt_q.size()); end
    order = 4'hF;
    if (gnt_q.size() >= 4)
      order = {gnt_q[0][0], gnt_q[1][0], gnt_q[2][0], gnt_q[3][0]};
    total++; if (order !== 4'b0101) begin bad++; $display("FAIL rr_order got=%b want=0101", order); end
    total++;
    if (gnt_dvcnt.size() < 4 || gnt_dvcnt[0] != 0 || gnt_dvcnt[1] != 4 || gnt_dvcnt[2] != 8 || gnt_dvcnt[3] != 12) begin
      bad++;
      $display("FAIL rr_gnt_after_dv got=%p want='{0,4,8,12}", gnt_dvcnt);
    end
    total++; if (dv0_cnt !== 8) begin bad++; $display("FAIL rr_dv0 got=%0d want=8", dv0_cnt); end
    total++; if (dv1_cnt !== 8) begin bad++; $display("FAIL rr_dv1 got=%0d want=8", dv1_cnt); end
  endtask

  task automatic test_busy_hold();
    int hold_bad;
    clr_counts();
    busy_left = 10;
    req1 = 1'b1; addr1 = 29'h1234567; len1 = 8'd3;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL busy_gnt1 got=%0h want=1", gnt1); end
    req1 = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ddr_rd !== 1'b1 || bus.ddr_addr !== 29'h1234567 || bus.ddr_burstcnt !== 8'd3) hold_bad++;
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL busy_hold got=%0d want=0", hold_bad); end
    @(negedge clk);
    total++; if (bus.ddr_rd !== 1'b0) begin bad++; $display("FAIL busy_accept got=%0h want=0", bus.ddr_rd); end
    wait_dv(1, 3, 50);
    idle(4);
    total++; if (dv1_cnt !== 3) begin bad++; $display("FAIL busy_dv1 got=%0d want=3", dv1_cnt); end
  endtask

  task automatic test_len_edges();
    clr_counts();
    req1 = 1'b1; addr1 = 29'h55; len1 = 8'd0;
    @(negedge clk);
    req1 = 1'b0;
    total++; if (bus.ddr_burstcnt !== 8'd1) begin bad++; $display("FAIL len0_burstcnt got=%0d want=1", bus.ddr_burstcnt); end
    wait_dv(1, 1, 50);
    idle(5);
    total++; if (dv1_cnt !== 1) begin bad++; $display("FAIL len0_dv1 got=%0d want=1", dv1_cnt); end
    clr_counts();
    req1 = 1'b1; addr1 = 29'h6000; len1 = 8'd200;
    @(negedge clk);
    req1 = 1'b0;
    total++; if (bus.ddr_burstcnt !== 8'd128) begin bad++; $display("FAIL len200_burstcnt got=%0d want=128", bus.ddr_burstcnt); end
    wait_dv(1, 128, 400);
    idle(5);
    total++; if (dv1_cnt !== 128) begin bad++; $display("FAIL len200_dv1 got=%0d want=128", dv1_cnt); end
  endtask

  task automatic test_stop();
    int s;
    clr_counts();
    req0 = 1'b1; addr0 = 29'h300; len0 = 8'd8;
    @(negedge clk);
    req0 = 1'b0;
    wait_dv(0, 3, 50);
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL stop_mid_burst got=%0h want=0", stopped); end
    stop_req = 1'b1;
    req0 = 1'b1;
    wait_dv(0, 8, 50);
    total++; if (dv0_cnt !== 8) begin bad++; $display("FAIL stop_drain got=%0d want=8", dv0_cnt); end
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL stop_stopped got=%0h want=1", stopped); end
    s = gnt_q.size();
    idle(20);
    total++; if (gnt_q.size() !== s) begin bad++; $display("FAIL stop_no_gnt got=%0d want=%0d", gnt_q.size(), s); end
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL stop_held got=%0h want=1", stopped); end
    stop_req = 1'b0;
    @(negedge clk);
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL stop_release got=%0h want=0", stopped); end
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL stop_gnt_early got=%0h want=0", gnt0); end
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL stop_gnt_after got=%0h want=1", gnt0); end
    req0 = 1'b0;
    wait_dv(0, 16, 50);
    idle(4);
    total++; if (dv0_cnt !== 16) begin bad++; $display("FAIL stop_second_burst got=%0d want=16", dv0_cnt); end
  endtask

  task automatic test_reset_midburst();
    clr_counts();
    req0 = 1'b1; addr0 = 29'h400; len0 = 8'd16;
    @(negedge clk);
    req0 = 1'b0;
    wait_dv(0, 5, 50);
    mem_en = 1'b0;
    bus.ddr_dout_ready = 1'b0;
    bus.ddr_busy = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if (dv0 !== 1'b0) begin bad++; $display("FAIL rmb_dv0 got=%0h want=0", dv0); end
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL rmb_rdata got=%0h want=0", rdata); end
    total++; if (bus.ddr_burstcnt !== 8'h0) begin bad++; $display("FAIL rmb_burstcnt got=%0h want=0", bus.ddr_burstcnt); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    clr_counts();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.ddr_dout = 64'hBEEF_0000 + 64'(i);
      bus.ddr_dout_ready = 1'b1;
    end
    @(negedge clk);
    bus.ddr_dout_ready = 1'b0;
    idle(2);
    total++; if (dv0_cnt + dv1_cnt !== 0) begin bad++; $display("FAIL rmb_stray_dv got=%0d want=0", dv0_cnt + dv1_cnt); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rmb_err got=%0h want=1", err); end
    idle(5);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rmb_err_sticky got=%0h want=1", err); end
  endtask

  task automatic test_invariants();
    total++; if (both_dv !== 1'b0) begin bad++; $display("FAIL inv_both_dv got=%0h want=0", both_dv); end
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL inv_gnt_dv got=%0h want=0", overlap); end
    total++; if (data_bad !== 0) begin bad++; $display("FAIL inv_data got=%0d want=0", data_bad); end
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0;
    len0 = '0; len1 = '0;
    stop_req = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_busy_hold();
    test_len_edges();
    test_stop();
    test_reset_midburst();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
